cmn_trace_reader: RTL and testbench

Consumer end of the packed line-trace string format. Accepts one packed trace line over a val/rdy interface and stores it in a local buffer. Serialises the line onto a byte-wide val/rdy character stream as "NNNN: <body>\n" (NNNN = decimal line number), for a hardware UART/JTAG trace sink. Sits between line-trace producers and any character-oriented output port.

---
 rtl/cmn_trace_reader_pkg.sv | 13 +
 rtl/cmn_trace_bcd_counter.sv | 26 ++
 rtl/cmn_trace_reader.sv | 111 +++++++++++
 tb/tb_cmn_trace_reader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cmn_trace_reader_pkg.sv
// cmn_trace_reader_pkg: FSM states and ASCII constants shared by the trace reader
package cmn_trace_reader_pkg;
   typedef enum logic [1:0] {IDLE, PREFIX, BODY, EOL} state_e;
   localparam logic [7:0] SPACE   = 8'h20;
   localparam logic [7:0] COLON   = 8'h3A;
   localparam logic [7:0] NEWLINE = 8'h0A;
   localparam logic [7:0] ZERO    = 8'h30;
   localparam int PREFIX_LEN = 6;
   // A suppressed leading zero prints as a space, otherwise the ASCII digit
   function automatic logic [7:0] digit_char(input logic [3:0] d, input logic lz);
      return lz ? SPACE : (ZERO | {4'h0, d});
   endfunction
endpackage

// File: rtl/cmn_trace_bcd_counter.sv
// cmn_trace_bcd_counter: N-digit BCD incrementer with wrap and leading-zero flags
module cmn_trace_bcd_counter #(
   parameter int N = 4
) (
   input  logic [4*N-1:0] val,
   output logic [4*N-1:0] nxt,
   output logic [N-1:0]   lz
);
   logic carry;
   logic zero_above;
   // Ripple +1 through the digits; lz[i] marks a digit that is zero along with every higher digit
   always_comb begin
      nxt = val;
      lz = '0;
      carry = 1'b1;
      zero_above = 1'b1;
      for (int i = 0; i < N; i++) begin
         nxt[4*i+:4] = carry ? ((val[4*i+:4] == 4'd9) ? 4'd0 : val[4*i+:4] + 4'd1) : val[4*i+:4];
         carry = carry && (val[4*i+:4] == 4'd9);
      end
      for (int i = N - 1; i > 0; i--) begin
         zero_above = zero_above && (val[4*i+:4] == 4'd0);
         lz[i] = zero_above;
      end
   end
endmodule

// File: rtl/cmn_trace_reader.sv
// cmn_trace_reader: buffers one packed trace line and streams it as "NNNN: <body>\n"
module cmn_trace_reader
   import cmn_trace_reader_pkg::*;
#(
   parameter int NCHARS = 512,
   parameter int IDXW   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                line_val,
   output logic                line_rdy,
   input  logic [NCHARS*8-1:0] line_data,
   output logic                out_val,
   input  logic                out_rdy,
   output logic [7:0]          out_char,
   output logic                busy
);
   localparam int PW = $clog2(NCHARS);
   localparam logic [PW-1:0] LAST = PW'(NCHARS - 1);

   state_e              state_q, state_d;
   logic [2:0]          pos_q, pos_d;
   logic [PW-1:0]       ptr_q, ptr_d, idx_q, idx_d, idx_cl;
   logic [NCHARS*8-1:0] buf_q, buf_d;
   logic [15:0]         cnt_q, cnt_d, pfx_q, pfx_d, cnt_nxt;
   logic [3:0]          lz_q, lz_d, cnt_lz;
   logic [7:0]          char_q, char_d;
   logic [1:0]          dsel;
   logic                up_q, acc, hs;
   logic [IDXW-1:0]     idx_raw;

   cmn_trace_bcd_counter #(.N(4)) u_bcd (.val(cnt_q), .nxt(cnt_nxt), .lz(cnt_lz));

   assign line_rdy = up_q && (state_q == IDLE);
   assign out_val  = state_q != IDLE;
   assign busy     = state_q != IDLE;
   assign out_char = char_q;
   assign acc      = line_val && line_rdy;
   assign hs       = out_val && out_rdy;
   assign idx_raw  = line_data[IDXW-1:0];
   // Clamping idx to 1..NCHARS-1 keeps the index bytes out of the body
   assign idx_cl   = (idx_raw == '0) ? PW'(1) : (32'(idx_raw) >= NCHARS - 1) ? LAST : PW'(idx_raw);

   // Next-state: capture on accept, advance the emit pointer on each output handshake
   always_comb begin
      state_d = state_q;
      pos_d = pos_q;
      ptr_d = ptr_q;
      idx_d = idx_q;
      buf_d = buf_q;
      cnt_d = cnt_q;
      pfx_d = pfx_q;
      lz_d = lz_q;
      if (acc) begin
         buf_d = line_data;
         idx_d = idx_cl;
         pfx_d = cnt_q;
         lz_d = cnt_lz;
         cnt_d = cnt_nxt;
         pos_d = 3'd0;
         state_d = en ? PREFIX : IDLE;
      end
      if (hs) begin
         case (state_q)
            PREFIX: begin
               pos_d = pos_q + 3'd1;
               ptr_d = LAST;
               if (pos_q == 3'(PREFIX_LEN - 1)) state_d = (idx_q == LAST) ? EOL : BODY;
            end
            BODY: begin
               ptr_d = ptr_q - PW'(1);
               if (ptr_q == idx_q + PW'(1)) state_d = EOL;
            end
            default: state_d = IDLE;
         endcase
      end
      dsel = 2'd3 - pos_d[1:0];
      char_d = (state_d == PREFIX) ? ((pos_d < 3'd4) ? digit_char(pfx_d[{dsel, 2'b00}+:4], lz_d[dsel]) :
                                      (pos_d == 3'd4) ? COLON : SPACE) :
               (state_d == BODY)   ? buf_d[{ptr_d, 3'b000}+:8] :
               (state_d == EOL)    ? NEWLINE : 8'h00;
   end

   // State registers; reset abandons any line in flight and zeroes the line counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pos_q <= '0;
         ptr_q <= '0;
         idx_q <= '0;
         buf_q <= '0;
         cnt_q <= '0;
         pfx_q <= '0;
         lz_q <= '0;
         char_q <= '0;
         up_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q <= pos_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         pfx_q <= pfx_d;
         lz_q <= lz_d;
         char_q <= char_d;
         up_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cmn_trace_reader.sv
// tb_cmn_trace_reader: directed vectors for the trace line serialiser
module tb_cmn_trace_reader;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         line_val = 1'b0;
   logic         line_rdy;
   logic [127:0] line_data = '0;
   logic         out_val;
   logic         out_rdy = 1'b1;
   logic [7:0]   out_char;
   logic         busy;
   int           checks = 0;
   int           errors = 0;
   string        got;

   typedef struct {
      bit    rst;
      string body;
      int    idx;
      bit    en;
      bit    bp;
      string exp;
   } vec_t;
   vec_t vecs[9];

   cmn_trace_reader #(.NCHARS(16), .IDXW(16)) dut (
      .clk(clk), .reset(reset), .en(en), .line_val(line_val), .line_rdy(line_rdy),
      .line_data(line_data), .out_val(out_val), .out_rdy(out_rdy), .out_char(out_char), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, g, e);
      end
   endtask

   task automatic chk_s(input string nm, input string g, input string e);
      checks++;
      if (g != e) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", nm, g, e);
      end
   endtask

   function automatic logic [127:0] mk(input string b, input int idx);
      logic [127:0] d = '0;
      for (int i = 0; i < b.len(); i++) d[(15 - i)*8+:8] = b[i];
      d[15:0] = 16'(idx);
      return d;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_out_val", out_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_char", out_char, 0);
      repeat (2) @(negedge clk);
      chk("rst_line_rdy_low", line_rdy, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_line_rdy_high", line_rdy, 1);
   endtask

   task automatic send(input logic [127:0] d, input bit e);
      line_data = d;
      en = e;
      line_val = 1'b1;
      for (int k = 0; k < 50 && !line_rdy; k++) @(negedge clk);
      if (!line_rdy) chk("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      line_val = 1'b0;
   endtask

   // Newline is recorded as '|' and NUL as '~' so the expected strings stay printable
   task automatic collect(input bit bp, output string s);
      bit         done = 0;
      bit         stall = 0;
      logic [7:0] held = '0;
      logic [7:0] c;
      s = "";
      for (int k = 0; k < 400 && !done; k++) begin
         if (stall) begin
            chk("stall_val", out_val, 1);
            chk("stall_char", out_char, held);
         end
         out_rdy = bp ? (k % 3 == 0) : 1'b1;
         if (bp) chk("bp_line_rdy", line_rdy, 0);
         stall = out_val && !out_rdy;
         held = out_char;
         if (out_val && out_rdy) begin
            c = (out_char == 8'h00) ? 8'h7e : (out_char == 8'h0a) ? 8'h7c : out_char;
            s = $sformatf("%s%c", s, c);
            done = out_char == 8'h0a;
         end
         @(negedge clk);
      end
      out_rdy = 1'b1;
      if (!done) chk("eol_timeout", 0, 1);
   endtask

   initial begin
      vecs[0] = '{1'b1, "hi", 13, 1'b1, 1'b0, "   0: hi|"};
      vecs[1] = '{1'b1, "", 15, 1'b1, 1'b0, "   0: |"};
      vecs[2] = '{1'b0, "a", 14, 1'b1, 1'b1, "   1: a|"};
      vecs[3] = '{1'b1, "x", 14, 1'b0, 1'b0, ""};
      vecs[4] = '{1'b0, "x", 14, 1'b1, 1'b0, "   1: x|"};
      vecs[5] = '{1'b0, "q", 12, 1'b1, 1'b0, "   2: q~~|"};
      vecs[6] = '{1'b0, "", 200, 1'b1, 1'b0, "   3: |"};
      vecs[7] = '{1'b0, "ABCDEFGHIJKLMN", 0, 1'b1, 1'b1, "   4: ABCDEFGHIJKLMN|"};
      vecs[8] = '{1'b0, "", 65535, 1'b1, 1'b0, "   5: |"};
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].rst) do_reset();
         send(mk(vecs[i].body, vecs[i].idx), vecs[i].en);
         chk($sformatf("v%0d_first_val", i), out_val, vecs[i].en);
         if (vecs[i].en) begin
            collect(vecs[i].bp, got);
            chk_s($sformatf("v%0d_stream", i), got, vecs[i].exp);
         end else begin
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_drop_val", i), out_val, 0);
         end
         chk($sformatf("v%0d_line_rdy", i), line_rdy, 1);
         chk($sformatf("v%0d_busy", i), busy, 0);
      end
      // Counter wrap: 9999 dropped lines, then 9999 prints and the count wraps to 0
      do_reset();
      line_data = mk("w", 14);
      en = 1'b0;
      line_val = 1'b1;
      repeat (9999) @(posedge clk);
      @(negedge clk);
      line_val = 1'b0;
      send(mk("z", 14), 1'b1);
      collect(1'b0, got);
      chk_s("wrap_9999", got, "9999: z|");
      send(mk("y", 14), 1'b1);
      collect(1'b0, got);
      chk_s("wrap_0", got, "   0: y|");
      // Asynchronous reset in the middle of the body
      send(mk("ABCDEFGHIJKLMN", 0), 1'b1);
      repeat (8) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_char", out_char, 8'h43);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_val", out_val, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy", line_rdy, 1);
      send(mk("hi", 13), 1'b1);
      collect(1'b0, got);
      chk_s("after_rst", got, "   0: hi|");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
